// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with pending-write scoreboard.
// Contents:
//   clog2      - address-width helper for a register count
//   ZERO_IDX   - index of the hardwired zero register
//   AW_DEF     - address width for the default 32-entry file
//   reg_addr_t - register address type for the default 32-entry file
package regfile_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam int unsigned ZERO_IDX = 0;
  localparam int unsigned AW_DEF   = clog2(32);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Selects the stored word, forwards same-cycle write-back data, forces register 0 to read as zero
// and raises a stall when the addressed register still waits for a load result.
// Ports:
//   in_rst  - reset is active; forces the read data and the stall flag to 0
//   raddr   - read address
//   regs    - storage array (all registers, flattened)
//   pending - pending-write bit per register
//   waddr   - write-back address of this cycle
//   wr_ok   - write-back enabled and not dropped
//   busW    - write-back data
//   rdata   - read data
//   stall   - addressed register has an unsatisfied pending write
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(NREGS)
) (
  input  logic                           in_rst,
  input  logic [AW-1:0]                  raddr,
  input  logic [NREGS-1:0][DATA_W-1:0]   regs,
  input  logic [NREGS-1:0]               pending,
  input  logic [AW-1:0]                  waddr,
  input  logic                           wr_ok,
  input  logic [DATA_W-1:0]              busW,
  output logic [DATA_W-1:0]              rdata,
  output logic                           stall
);

  logic hit;

  assign hit = (BYPASS != 0) && wr_ok && (waddr == raddr);

  always_comb begin
    rdata = hit ? busW : regs[raddr];
    // Zero forcing overrides the bypass as well.
    if ((ZERO_REG != 0) && (raddr == AW'(ZERO_IDX))) begin
      rdata = '0;
    end
    if (in_rst) begin
      rdata = '0;
    end
  end

  // A write-back landing this cycle satisfies the pending load only when it is forwarded.
  assign stall = ~in_rst & pending[raddr] & ~hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// MIPS register file for the ID stage: two combinational read ports with write-back bypass,
// one write port, a debug read port and a pending-write scoreboard for load-use hazards.
// Ports:
//   clk, arst_n           - clock, asynchronous active-low reset
//   clr                   - synchronous clear of all registers and pending bits
//   Rs, Rt, Rd, RegDst    - read addresses; write address is RegDst ? Rd : Rt
//   RegWr, busW           - write enable and write data from WB
//   busA, busB            - read data for Rs and Rt
//   mark_vld, mark_addr   - mark a register pending (load issued)
//   stall_a, stall_b      - Rs / Rt wait on a pending write
//   dbg_addr, dbg_data    - debug read, never bypassed
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic [AW-1:0]     Rs,
  input  logic [AW-1:0]     Rt,
  input  logic [AW-1:0]     Rd,
  input  logic              RegDst,
  input  logic              RegWr,
  input  logic [DATA_W-1:0] busW,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic              mark_vld,
  input  logic [AW-1:0]     mark_addr,
  output logic              stall_a,
  output logic              stall_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0]             pending_q, pending_d;
  logic [AW-1:0]                waddr;
  logic                         wr_ok, mk_ok, in_rst;

  assign in_rst = ~arst_n;
  assign waddr  = RegDst ? Rd : Rt;
  assign wr_ok  = RegWr & ~((ZERO_REG != 0) && (waddr == AW'(ZERO_IDX)));
  assign mk_ok  = mark_vld & ~((ZERO_REG != 0) && (mark_addr == AW'(ZERO_IDX)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      regs_q <= '0;
    end else if (clr) begin
      regs_q <= '0;
    end else if (wr_ok) begin
      regs_q[waddr] <= busW;
    end
  end

  // Mark is applied after the write clear so a newer load in flight keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) begin
      pending_d[waddr] = 1'b0;
    end
    if (mk_ok) begin
      pending_d[mark_addr] = 1'b1;
    end
    if (clr) begin
      pending_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rd_a (
    .in_rst  (in_rst),
    .raddr   (Rs),
    .regs    (regs_q),
    .pending (pending_q),
    .waddr   (waddr),
    .wr_ok   (wr_ok),
    .busW    (busW),
    .rdata   (busA),
    .stall   (stall_a)
  );

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rd_b (
    .in_rst  (in_rst),
    .raddr   (Rt),
    .regs    (regs_q),
    .pending (pending_q),
    .waddr   (waddr),
    .wr_ok   (wr_ok),
    .busW    (busW),
    .rdata   (busB),
    .stall   (stall_b)
  );

  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (bypass on / off) share every input.
// Expected values are queued as stimulus is driven and compared once the outputs settle.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic        clk, arst_n, clr, RegDst, RegWr, mark_vld;
  reg_addr_t   Rs, Rt, Rd, mark_addr, dbg_addr;
  logic [31:0] busW;

  logic [31:0] busA1, busB1, dbg1, busA0, busB0, dbg0;
  logic        sa1, sb1, sa0, sb0;

  regfile_scoreboard #(.DATA_W(32), .NREGS(32), .BYPASS(1), .ZERO_REG(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .clr(clr), .Rs(Rs), .Rt(Rt), .Rd(Rd), .RegDst(RegDst),
    .RegWr(RegWr), .busW(busW), .busA(busA1), .busB(busB1), .mark_vld(mark_vld),
    .mark_addr(mark_addr), .stall_a(sa1), .stall_b(sb1), .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  regfile_scoreboard #(.DATA_W(32), .NREGS(32), .BYPASS(0), .ZERO_REG(1)) dut0 (
    .clk(clk), .arst_n(arst_n), .clr(clr), .Rs(Rs), .Rt(Rt), .Rd(Rd), .RegDst(RegDst),
    .RegWr(RegWr), .busW(busW), .busA(busA0), .busB(busB0), .mark_vld(mark_vld),
    .mark_addr(mark_addr), .stall_a(sa0), .stall_b(sb0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int A1 = 0, B1 = 1, D1 = 2, SA1 = 3, SB1 = 4, A0 = 5, D0 = 6, SA0 = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      A1:      return busA1;
      B1:      return busB1;
      D1:      return dbg1;
      SA1:     return {31'd0, sa1};
      SB1:     return {31'd0, sb1};
      A0:      return busA0;
      D0:      return dbg0;
      SA0:     return {31'd0, sa0};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    q.push_back(e);
  endtask

  // Outputs are combinational; let them settle, then score every queued expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (q.size() != 0) begin
      e = q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    RegWr = 1'b0; mark_vld = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input reg_addr_t a, input logic [31:0] d);
    RegDst = 1'b1; Rd = a; busW = d; RegWr = 1'b1;
  endtask

  initial begin
    // Reset asserted while a bypassing write is presented: reads still 0.
    arst_n = 1'b0; clr = 1'b0; mark_vld = 1'b0; mark_addr = 5'd0; dbg_addr = 5'd3;
    Rs = 5'd3; Rt = 5'd3; wr(5'd3, 32'hFFFF_0000);
    #2;
    push("rst_busA", A1, 32'h0); push("rst_busB", B1, 32'h0); push("rst_dbg", D1, 32'h0);
    push("rst_sa", SA1, 32'h0); push("rst_sb", SB1, 32'h0);
    drain();
    @(negedge clk);
    arst_n = 1'b1; idle();
    push("post_rst_busA", A1, 32'h0); push("post_rst_dbg", D1, 32'h0);
    drain();
    cycle();
    push("idle_busA", A1, 32'h0); push("idle_sa", SA1, 32'h0);
    drain();

    // Write then read; bypass instance forwards, the other shows the old value.
    wr(5'd3, 32'hDEAD_BEEF); Rs = 5'd3; Rt = 5'd0;
    push("byp_r3", A1, 32'hDEAD_BEEF); push("nobyp_r3", A0, 32'h0);
    drain();
    cycle(); idle();
    push("rd_r3", A1, 32'hDEAD_BEEF); push("rd_r0", B1, 32'h0); push("rd_r3_b0", A0, 32'hDEAD_BEEF);
    drain();
    RegDst = 1'b0; Rt = 5'd5; busW = 32'h1234; RegWr = 1'b1;
    push("rt_wr_byp", B1, 32'h1234);
    drain();
    cycle(); idle(); dbg_addr = 5'd5;
    push("dbg_r5", D1, 32'h1234); push("dbg_r5_b0", D0, 32'h1234);
    drain();

    // Bypass against an existing value.
    wr(5'd7, 32'h1111_1111); cycle();
    wr(5'd7, 32'hA5A5_A5A5); Rs = 5'd7; dbg_addr = 5'd7;
    push("byp_r7", A1, 32'hA5A5_A5A5); push("nobyp_r7", A0, 32'h1111_1111);
    push("dbg_no_byp", D1, 32'h1111_1111);
    drain();
    cycle(); idle();
    push("r7_after", A0, 32'hA5A5_A5A5);
    drain();

    // Zero register: write and mark both dropped.
    wr(5'd0, 32'hFFFF_FFFF); mark_vld = 1'b1; mark_addr = 5'd0; Rs = 5'd0; dbg_addr = 5'd0;
    push("z_byp", A1, 32'h0); push("z_sa", SA1, 32'h0);
    drain();
    cycle(); idle();
    push("z_after", A1, 32'h0); push("z_sa_after", SA1, 32'h0); push("z_dbg", D1, 32'h0);
    drain();

    // Scoreboard: a mark does not stall the same cycle's read.
    mark_vld = 1'b1; mark_addr = 5'd9; Rs = 5'd9;
    push("mark_same_cyc", SA1, 32'h0);
    drain();
    cycle(); idle();
    push("pend9_sa", SA1, 32'h1); push("pend9_sa0", SA0, 32'h1);
    drain();
    wr(5'd9, 32'h42);
    push("wb9_sa", SA1, 32'h0); push("wb9_busA", A1, 32'h42); push("wb9_sa0", SA0, 32'h1);
    drain();
    cycle(); idle();
    push("clr9_sa", SA1, 32'h0); push("clr9_sa0", SA0, 32'h0);
    drain();
    // Mark and write to the same register: data lands, mark wins.
    wr(5'd9, 32'h99); mark_vld = 1'b1; mark_addr = 5'd9;
    cycle(); idle(); Rt = 5'd9; dbg_addr = 5'd9;
    push("mw9_dbg", D1, 32'h99); push("mw9_sa", SA1, 32'h1); push("mw9_sb", SB1, 32'h1);
    drain();

    // Synchronous clear beats a same-cycle write and mark.
    wr(5'd3, 32'h55); cycle();
    clr = 1'b1; wr(5'd4, 32'h77); mark_vld = 1'b1; mark_addr = 5'd10;
    cycle(); idle(); Rs = 5'd3; Rt = 5'd9; dbg_addr = 5'd4;
    push("clr_r3", A1, 32'h0); push("clr_sb9", SB1, 32'h0); push("clr_r4", D1, 32'h0);
    drain();
    Rs = 5'd10;
    push("clr_sa10", SA1, 32'h0);
    drain();

    // Asynchronous reset glitch between edges.
    wr(5'd3, 32'h55); mark_vld = 1'b1; mark_addr = 5'd9;
    cycle(); idle(); Rs = 5'd3; Rt = 5'd9;
    push("pre_gl_r3", A1, 32'h55); push("pre_gl_sb", SB1, 32'h1);
    drain();
    #1 arst_n = 1'b0;
    #1 arst_n = 1'b1;
    dbg_addr = 5'd3;
    push("gl_r3", A1, 32'h0); push("gl_sb", SB1, 32'h0); push("gl_dbg", D1, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
